// File: rtl/systolic_feeder_if.sv
// Handshake/bus bundle for systolic_feeder.
// Ports: in_valid/in_ready/in_row row load, start, X/x_valid/busy/done stream out.
interface systolic_feeder_if #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH*N-1:0] in_row;
  logic                    start;
  logic [DATA_WIDTH*N-1:0] X;
  logic                    x_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output in_valid, in_row, start,
    input  in_ready, X, x_valid, busy, done
  );

  modport slave (
    input  in_valid, in_row, start,
    output in_ready, X, x_valid, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers an MxN matrix row by row, then streams it diagonally skewed to a systolic array.
// Ports: clk, rst (sync, active-high), bus (slave side of systolic_feeder_if).
module systolic_feeder #(
  parameter int M          = 5,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  systolic_feeder_if.slave bus
);
  localparam int W  = DATA_WIDTH * N;
  localparam int TW = (M + N - 1 > 1) ? $clog2(M + N - 1) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    LOAD,
    FULL,
    STREAM
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic [TW-1:0]         t_q, t_d;
  logic [W-1:0]          x_q, x_d;
  logic                  x_valid_q, x_valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] buf_q [M][N];
  logic                  accept;
  logic [TW-1:0]         beat_idx;
  logic [W-1:0]          beat;

  assign accept       = bus.in_valid && (state_q == LOAD);
  assign bus.in_ready = (state_q == LOAD);
  assign bus.busy     = (state_q != LOAD);
  assign bus.X        = x_q;
  assign bus.x_valid  = x_valid_q;
  assign bus.done     = done_q;

  // Beat being loaded into X on the next edge: 0 on start, t+1 mid-stream.
  assign beat_idx = (state_q == STREAM) ? t_q + TW'(1) : '0;

  // Lane j of beat t is row (t-j); out-of-range rows give zero.
  always_comb begin
    beat = '0;
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < M; r++) begin
        if (int'(beat_idx) == r + j) begin
          beat[j*DATA_WIDTH +: DATA_WIDTH] = buf_q[r][j];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    t_d       = t_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    done_d    = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (row_cnt_q == RW'(M - 1)) begin
            row_cnt_d = '0;
            state_d   = FULL;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
          end
        end
      end
      FULL: begin
        if (bus.start) begin
          state_d   = STREAM;
          t_d       = '0;
          x_d       = beat;
          x_valid_d = 1'b1;
        end
      end
      STREAM: begin
        if (t_q == TW'(M + N - 2)) begin
          state_d   = LOAD;
          t_d       = '0;
          x_d       = '0;
          x_valid_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          t_d = t_q + TW'(1);
          x_d = beat;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
      t_q       <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      t_q       <= t_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  // Matrix storage has no reset; every load overwrites all rows.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int r = 0; r < M; r++) begin
        if (row_cnt_q == RW'(r)) begin
          for (int j = 0; j < N; j++) begin
            buf_q[r][j] <= bus.in_row[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end
endmodule
